rat_intr_ctrl: RTL
==================

# rat_intr_ctrl

Interrupt controller that merges up to eight peripheral interrupt sources into the single `INTR` input of the RAT MCU. It latches source events, applies a CPU-programmable mask, selects the highest-priority pending source, and holds `INTR` until software acknowledges it, followed by a fixed holdoff so the `RETIE` sequence can complete. It sits on the MCU I/O bus: configured by `OUT` writes (`PORT_ID`/`OUT_PORT`/`IO_STRB`) and read back through the top-level `IN_PORT` mux.

## Interface
- `NUM_SRC`, 8 — number of interrupt sources, 1..8; index 0 is highest priority.
- `MASK_PORT`, 8'hF0 — port ID of the mask register (write; 1 = enabled).
- `ACK_PORT`, 8'hF1 — port ID of the acknowledge register (write-1-to-clear pending).
- `STAT_PORT`, 8'hF2 — port ID for reading `pending & mask`.
- `ID_PORT`, 8'hF3 — port ID for reading the current vector.
- `HOLDOFF`, 4 — cycles after acknowledge before re-arbitration, 1..15.

- `CLK` in 1 — system clock; all state changes on the rising edge.
- `RESET` in 1 — synchronous, active-high reset.
- `IRQ` in NUM_SRC — raw source requests, synchronous to `CLK`.
- `PORT_ID` in 8 — MCU port address.
- `OUT_PORT` in 8 — MCU output data.
- `IO_STRB` in 1 — MCU output write strobe, one cycle per `OUT`.
- `INTR` out 1 — registered interrupt request to the MCU.
- `INTR_DOUT` out 8 — combinational read data for `STAT_PORT`/`ID_PORT`, 0 for any other `PORT_ID`.
- `INTR_RD_HIT` out 1 — combinational: `PORT_ID` equals `STAT_PORT` or `ID_PORT`; selects `INTR_DOUT` in the `IN_PORT` mux.

## Operation
- Registers: `mask[NUM_SRC-1:0]`, `pending[NUM_SRC-1:0]`, `irq_q[NUM_SRC-1:0]`, `cur_id[2:0]`, `hold_cnt[3:0]`, and a 3-state FSM.
- Reset: `mask`=0, `pending`=0, `cur_id`=0, `hold_cnt`=0, FSM=IDLE, `INTR`=0. During reset `irq_q` loads `IRQ`, so a source held high through reset does not create an event.
- Event detect: `irq_q` <= `IRQ` every cycle. An event on source i is `IRQ[i] & ~irq_q[i]`, and it sets `pending[i]`.
- Writes, qualified by `IO_STRB`:
  - `MASK_PORT`: `mask` <= `OUT_PORT[NUM_SRC-1:0]`.
  - `ACK_PORT`: `pending` <= `pending & ~OUT_PORT[NUM_SRC-1:0]`.
  - An event and a clear on the same bit in the same cycle leaves the bit set; set wins, and no event is lost.
  - Bits above `NUM_SRC-1` are ignored on write and read as 0.
- Reads:
  - `STAT_PORT` returns `pending & mask`, zero-extended.
  - `ID_PORT` returns `{valid, 4'b0, cur_id}`; `valid`=1 only in state REQ.
- `active` = `pending & mask`; `sel` = lowest set index of `active`.
- FSM states:
  - IDLE: `INTR`=0. If `active`≠0, latch `cur_id`<=`sel` and go to REQ.
  - REQ: `INTR`=1. `cur_id` is frozen; a newly pending higher-priority source does not preempt.
    - If `active[cur_id]`=0 (acknowledged or masked), go to HOLD and load `hold_cnt`<=`HOLDOFF-1`.
  - HOLD: `INTR`=0. Decrement `hold_cnt`; at 0, go to IDLE. Events still latch during HOLD.
- Clearing mask bits never clears `pending`; re-enabling a mask bit re-exposes the stored event.

## Timing
- `INTR` is a registered output, driven by the FSM state flop.
- Event latency:
  - `IRQ[i]` is first sampled high at edge k (previous sample low), so `pending[i]`=1 after edge k.
  - FSM enters REQ at edge k+1, so `INTR`=1 after edge k+1.
- Release: an acknowledge write sampled at edge m clears the pending bit at m. `INTR`=0 after edge m+1 (REQ→HOLD).
- Re-arbitration: the earliest next `INTR` rise is after edge m+1+`HOLDOFF`+1.
- Writes take effect on the edge where `IO_STRB` is sampled. Reads are combinational with no added latency.
- Reset asserted mid-request drops `INTR` the cycle after the reset edge and discards all pending events.

## Configuration
- `INTR_EDGE_EN` defined: edge-triggered latching as described above.
- `INTR_EDGE_EN` undefined: level-sensitive mode.
  - `pending` <= `IRQ` every cycle; `ACK_PORT` writes have no effect.
  - REQ exits when the source deasserts or is masked.
  - Same latency: `IRQ` high sampled at k → `INTR`=1 after k+1.

## Test plan
- Reset with `IRQ`=8'h01 held high, then `mask`=8'h01 → `INTR` stays 0 (edge build); in level mode `INTR`=1 two cycles after the mask write.
- `mask`=8'hFF; rise `IRQ[5]` and `IRQ[2]` in the same cycle → `INTR`=1 two cycles later; `ID_PORT` reads 8'h82; `STAT_PORT` reads 8'h24.
- Write 8'h04 to `ACK_PORT` → `INTR`=0 next cycle; after `HOLDOFF`=4 cycles `INTR`=1 again; `ID_PORT` reads 8'h85.
- Rise `IRQ[3]` in the same cycle as an ACK write of 8'h08 → `pending[3]` stays 1; `STAT_PORT` bit 3 reads 1.
- While in REQ on source 5, write `mask`=8'h00 → `INTR`=0 next cycle; `pending[5]` retained; after `mask`=8'h20, `INTR` reasserts once `HOLDOFF` expires.
- Assert `RESET` for one cycle while `INTR`=1 → `INTR`=0, `STAT_PORT` reads 0, `mask`=0.

Source files
------------

// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: prioritised interrupt merger driving the RAT MCU INTR input; define INTR_EDGE_EN for edge-latched sources (level-sensitive otherwise)
module rat_intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter logic [7:0] MASK_PORT = 8'hF0,
`ifdef INTR_EDGE_EN
  parameter logic [7:0] ACK_PORT = 8'hF1,
`endif
  parameter logic [7:0] STAT_PORT = 8'hF2,
  parameter logic [7:0] ID_PORT = 8'hF3,
  parameter int HOLDOFF = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic               INTR,
  output logic [7:0]         INTR_DOUT,
  output logic               INTR_RD_HIT
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] mask_q, mask_d, pending_q, pending_d, active;
  logic [7:0] act8;
  logic [2:0] cur_id_q, cur_id_d, sel;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic intr_q, intr_d;
`ifdef INTR_EDGE_EN
  logic [NUM_SRC-1:0] irq_q;
`endif
  assign active = pending_q & mask_q;
  assign act8 = 8'(active);
  always_comb begin
    mask_d = (IO_STRB && PORT_ID == MASK_PORT) ? OUT_PORT[NUM_SRC-1:0] : mask_q;
`ifdef INTR_EDGE_EN
    pending_d = (pending_q & ~((IO_STRB && PORT_ID == ACK_PORT) ? OUT_PORT[NUM_SRC-1:0] : '0)) | (IRQ & ~irq_q);
`else
    pending_d = IRQ;
`endif
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) sel = active[i] ? 3'(i) : sel;
    state_d = state_q;
    cur_id_d = cur_id_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = |active ? REQ : IDLE;
        cur_id_d = |active ? sel : cur_id_q;
      end
      REQ: begin
        state_d = act8[cur_id_q] ? REQ : HOLD;
        hold_cnt_d = act8[cur_id_q] ? hold_cnt_q : 4'(HOLDOFF - 1);
      end
      HOLD: begin
        state_d = hold_cnt_q == 4'd0 ? IDLE : HOLD;
        hold_cnt_d = hold_cnt_q == 4'd0 ? 4'd0 : hold_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    intr_d = state_d == REQ;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      mask_q <= '0;
      pending_q <= '0;
      cur_id_q <= '0;
      hold_cnt_q <= '0;
      intr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      pending_q <= pending_d;
      cur_id_q <= cur_id_d;
      hold_cnt_q <= hold_cnt_d;
      intr_q <= intr_d;
    end
`ifdef INTR_EDGE_EN
    irq_q <= IRQ;
`endif
  end
  assign INTR = intr_q;
  assign INTR_RD_HIT = PORT_ID == STAT_PORT || PORT_ID == ID_PORT;
  assign INTR_DOUT = PORT_ID == STAT_PORT ? act8 :
                     PORT_ID == ID_PORT ? {state_q == REQ, 4'b0, cur_id_q} : 8'h00;
endmodule
